// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot pixel sequencer.
// Coordinates are signed fixed point Q8.24 by default.
package mandelbrot_pkg;

  localparam int INTEGER_BITS_DEF    = 8;
  localparam int FRACTIONAL_BITS_DEF = 24;
  localparam int MAX_ITER_WIDTH_DEF  = 16;
  localparam int COORD_WIDTH_DEF     = 12;
  localparam int DATA_WIDTH          = INTEGER_BITS_DEF + FRACTIONAL_BITS_DEF;

  // 1.0 in the coordinate format
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRACTIONAL_BITS_DEF;

  typedef logic signed [DATA_WIDTH-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUTPUT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/mandelbrot_pixel_sequencer_raster_counter.sv
// Raster position and complex-coordinate accumulators for the pixel sequencer.
// init_i restarts at (0,0); advance_i steps one pixel in raster order.
module raster_counter #(
  parameter int CW = 12,
  parameter int DW = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_i,
  input  logic                 advance_i,
  input  logic [CW-1:0]        width_i,
  input  logic [CW-1:0]        height_i,
  input  logic signed [DW-1:0] x_init_i,
  input  logic signed [DW-1:0] y_init_i,
  input  logic signed [DW-1:0] x_min_i,
  input  logic signed [DW-1:0] step_i,
  output logic [CW-1:0]        px_o,
  output logic [CW-1:0]        py_o,
  output logic signed [DW-1:0] x_acc_o,
  output logic signed [DW-1:0] y_acc_o,
  output logic                 eol_o,
  output logic                 last_o
);

  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0]        px_q, px_d, py_q, py_d;
  logic signed [DW-1:0] x_acc_q, x_acc_d, y_acc_q, y_acc_d;

  assign eol_o   = (px_q == width_i - ONE_C);
  assign last_o  = eol_o && (py_q == height_i - ONE_C);
  assign px_o    = px_q;
  assign py_o    = py_q;
  assign x_acc_o = x_acc_q;
  assign y_acc_o = y_acc_q;

  // Next position: restart on init, otherwise step along the line or wrap to the next line.
  always_comb begin
    px_d    = px_q;
    py_d    = py_q;
    x_acc_d = x_acc_q;
    y_acc_d = y_acc_q;
    if (init_i) begin
      px_d    = '0;
      py_d    = '0;
      x_acc_d = x_init_i;
      y_acc_d = y_init_i;
    end else if (advance_i) begin
      if (!eol_o) begin
        px_d    = px_q + ONE_C;
        x_acc_d = x_acc_q + step_i;
      end else begin
        px_d    = '0;
        x_acc_d = x_min_i;
        py_d    = py_q + ONE_C;
        y_acc_d = y_acc_q + step_i;
      end
    end
  end

  // Position and accumulator registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      px_q    <= '0;
      py_q    <= '0;
      x_acc_q <= '0;
      y_acc_q <= '0;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      x_acc_q <= x_acc_d;
      y_acc_q <= y_acc_d;
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_sequencer.sv
// Frame sequencer feeding one mandelbrotCore and emitting a valid/ready pixel stream.
// Optional build macro MANDEL_SEQ_PERF_EN adds frame_iter_sum_o (per-frame sum of iteration counts).
//
// state  | meaning
// IDLE   | waiting for frame_start_i
// ISSUE  | core_start_o pulse with current c
// WAIT   | waiting for core_done_i, capture result
// OUTPUT | pixel presented, waiting for pix_ready_i
// DONE   | frame finished; frame_done_o pulses the following cycle
//
// busy_o stays high through the frame_done_o cycle so a new frame can never be
// accepted before the previous completion pulse has been seen.
module mandelbrot_pixel_sequencer
  import mandelbrot_pkg::*;
#(
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int COORD_WIDTH     = 12,
  localparam int DW             = INTEGER_BITS + FRACTIONAL_BITS
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      frame_start_i,
  input  logic [COORD_WIDTH-1:0]    width_i,
  input  logic [COORD_WIDTH-1:0]    height_i,
  input  logic signed [DW-1:0]      x_min_i,
  input  logic signed [DW-1:0]      y_min_i,
  input  logic signed [DW-1:0]      step_i,
  input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
  output logic                      core_start_o,
  output logic signed [DW-1:0]      core_x0_o,
  output logic signed [DW-1:0]      core_y0_o,
  output logic [MAX_ITER_WIDTH-1:0] core_max_iter_o,
  input  logic [MAX_ITER_WIDTH-1:0] core_iter_i,
  input  logic                      core_done_i,
  output logic                      pix_valid_o,
  input  logic                      pix_ready_i,
  output logic [MAX_ITER_WIDTH-1:0] pix_iter_o,
  output logic [COORD_WIDTH-1:0]    pix_x_o,
  output logic [COORD_WIDTH-1:0]    pix_y_o,
  output logic                      pix_sof_o,
  output logic                      pix_eol_o,
  output logic                      busy_o,
  output logic                      frame_done_o
`ifdef MANDEL_SEQ_PERF_EN
  ,
  output logic [31:0]               frame_iter_sum_o
`endif
);

  seq_state_e                state_q, state_d;
  logic [COORD_WIDTH-1:0]    width_q, width_d, height_q, height_d;
  logic signed [DW-1:0]      x_min_q, x_min_d, step_q, step_d;
  logic [MAX_ITER_WIDTH-1:0] max_iter_q, max_iter_d;
  logic                      core_start_q, core_start_d;
  logic                      pix_valid_q, pix_valid_d;
  logic [MAX_ITER_WIDTH-1:0] pix_iter_q, pix_iter_d;
  logic [COORD_WIDTH-1:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic                      pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;
  logic                      busy_q, busy_d, frame_done_q, frame_done_d;
  logic                      init, advance, eol, last;
  logic [COORD_WIDTH-1:0]    px, py;
`ifdef MANDEL_SEQ_PERF_EN
  logic [31:0]               sum_q, sum_d;
`endif

  raster_counter #(.CW(COORD_WIDTH), .DW(DW)) u_raster (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .init_i    (init),
    .advance_i (advance),
    .width_i   (width_q),
    .height_i  (height_q),
    .x_init_i  (x_min_i),
    .y_init_i  (y_min_i),
    .x_min_i   (x_min_q),
    .step_i    (step_q),
    .px_o      (px),
    .py_o      (py),
    .x_acc_o   (core_x0_o),
    .y_acc_o   (core_y0_o),
    .eol_o     (eol),
    .last_o    (last)
  );

  // Next-state and registered-output logic for the frame FSM.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    x_min_d      = x_min_q;
    step_d       = step_q;
    max_iter_d   = max_iter_q;
    pix_iter_d   = pix_iter_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_sof_d    = pix_sof_q;
    pix_eol_d    = pix_eol_q;
    init         = 1'b0;
    advance      = 1'b0;
`ifdef MANDEL_SEQ_PERF_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (frame_start_i && !busy_q) begin
          width_d    = width_i;
          height_d   = height_i;
          x_min_d    = x_min_i;
          step_d     = step_i;
          max_iter_d = max_iter_i;
          init       = 1'b1;
`ifdef MANDEL_SEQ_PERF_EN
          sum_d      = '0;
`endif
          state_d    = (width_i == '0 || height_i == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      // done is still high from the previous pixel here, so it is not sampled
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done_i) begin
          pix_iter_d = core_iter_i;
          pix_x_d    = px;
          pix_y_d    = py;
          pix_sof_d  = (px == '0) && (py == '0);
          pix_eol_d  = eol;
`ifdef MANDEL_SEQ_PERF_EN
          sum_d      = sum_q + {{(32-MAX_ITER_WIDTH){1'b0}}, core_iter_i};
`endif
          state_d    = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (pix_ready_i) begin
          advance = 1'b1;
          state_d = last ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    core_start_d = (state_d == ST_ISSUE);
    pix_valid_d  = (state_d == ST_OUTPUT);
    frame_done_d = (state_q == ST_DONE);
    busy_d       = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  // FSM state, latched frame parameters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      x_min_q      <= '0;
      step_q       <= '0;
      max_iter_q   <= '0;
      core_start_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_iter_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef MANDEL_SEQ_PERF_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      x_min_q      <= x_min_d;
      step_q       <= step_d;
      max_iter_q   <= max_iter_d;
      core_start_q <= core_start_d;
      pix_valid_q  <= pix_valid_d;
      pix_iter_q   <= pix_iter_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_sof_q    <= pix_sof_d;
      pix_eol_q    <= pix_eol_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef MANDEL_SEQ_PERF_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign core_start_o    = core_start_q;
  assign core_max_iter_o = max_iter_q;
  assign pix_valid_o     = pix_valid_q;
  assign pix_iter_o      = pix_iter_q;
  assign pix_x_o         = pix_x_q;
  assign pix_y_o         = pix_y_q;
  assign pix_sof_o       = pix_sof_q;
  assign pix_eol_o       = pix_eol_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = frame_done_q;
`ifdef MANDEL_SEQ_PERF_EN
  assign frame_iter_sum_o = sum_q;
`endif

endmodule
